// File: rtl/gsensor_spi_reader_pkg.sv
// Shared constants and FSM encoding for the ADXL345 SPI reader.
// Register addresses, config values, read command flags, state type.
package gsensor_spi_reader_pkg;

  localparam logic [7:0] REG_DATA_FORMAT = 8'h31;
  localparam logic [7:0] REG_POWER_CTL   = 8'h2D;
  localparam logic [7:0] REG_DATAX0      = 8'h32;

  localparam logic [7:0] CFG_DATA_FORMAT = 8'h00;
  localparam logic [7:0] CFG_POWER_CTL   = 8'h08;

  localparam logic [7:0] CMD_READ = 8'h80;
  localparam logic [7:0] CMD_MB   = 8'h40;
  localparam logic [7:0] READ_CMD = CMD_READ | CMD_MB | REG_DATAX0;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_WR_FMT,
    ST_WR_PWR,
    ST_IDLE,
    ST_READ,
    ST_UPDATE
  } state_t;

endpackage

// File: rtl/gsensor_spi_xfer.sv
// Byte-count-driven SPI mode 3 transaction engine (MSB first).
// Ports: start/nbytes in, tx per byte_idx, rx+rx_strobe, done, SPI pins.
module gsensor_spi_xfer #(
  parameter int CLK_DIV = 13
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] nbytes,
  input  logic [7:0] tx,
  output logic [2:0] byte_idx,
  output logic [7:0] rx,
  output logic       rx_strobe,
  output logic       done,
  output logic       spi_cs_n,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] cnt;
  logic [6:0]    lvl;
  logic [6:0]    nxt;
  logic [2:0]    nb;
  logic [7:0]    txs;
  logic [7:0]    rxs;
  logic          busy;
  logic          hp_end;
  logic          last;

  // lvl 0 is the lead-in half-period with cs_n low and sclk high;
  // odd levels are sclk low, even levels sclk high.  The final high
  // level doubles as the trailing half-period before cs_n rises.
  assign hp_end   = cnt == DW'(CLK_DIV - 1);
  assign nxt      = lvl + 7'd1;
  assign last     = lvl == {nb, 4'b0000};
  assign byte_idx = lvl[6:4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      spi_cs_n  <= 1'b1;
      spi_sclk  <= 1'b1;
      spi_mosi  <= 1'b0;
      cnt       <= '0;
      lvl       <= '0;
      nb        <= '0;
      txs       <= '0;
      rxs       <= '0;
      rx        <= '0;
      rx_strobe <= 1'b0;
      done      <= 1'b0;
    end else begin
      rx_strobe <= 1'b0;
      done      <= 1'b0;
      if (!busy) begin
        if (start) begin
          busy     <= 1'b1;
          spi_cs_n <= 1'b0;
          cnt      <= '0;
          lvl      <= '0;
          nb       <= nbytes;
        end
      end else if (!hp_end) begin
        cnt <= cnt + DW'(1);
      end else begin
        cnt <= '0;
        if (last) begin
          busy     <= 1'b0;
          spi_cs_n <= 1'b1;
          done     <= 1'b1;
        end else begin
          lvl      <= nxt;
          spi_sclk <= ~nxt[0];
          if (!lvl[0]) begin
            if (lvl[3:0] == 4'd0) begin
              spi_mosi <= tx[7];
              txs      <= {tx[6:0], 1'b0};
            end else begin
              spi_mosi <= txs[7];
              txs      <= {txs[6:0], 1'b0};
            end
          end else begin
            rxs <= {rxs[6:0], spi_miso};
            if (lvl[3:0] == 4'hF) begin
              rx        <= {rxs[6:0], spi_miso};
              rx_strobe <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/gsensor_spi_reader.sv
// ADXL345 configure-then-poll reader presenting 10-bit X/Y samples.
// Ports: clk, rst_n, SPI pins, x_acc, y_acc, acc_valid, init_done.
module gsensor_spi_reader #(
  parameter int CLK_DIV       = 13,
  parameter int PWRUP_WAIT    = 50000,
  parameter int SAMPLE_PERIOD = 250000,
  parameter int CS_GAP        = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       spi_cs_n,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic [9:0] x_acc,
  output logic [9:0] y_acc,
  output logic       acc_valid,
  output logic       init_done
);

  import gsensor_spi_reader_pkg::*;

  localparam int GAP    = CS_GAP * CLK_DIV;
  localparam int GAP_LD = (GAP > 0) ? GAP - 1 : 0;
  localparam int PW     = $clog2(PWRUP_WAIT + 1);
  localparam int SW     = $clog2(SAMPLE_PERIOD + 1);
  localparam int GW     = $clog2(GAP + 2);

  state_t        state;
  state_t        nstate;
  logic [PW-1:0] pw_cnt;
  logic [SW-1:0] timer;
  logic [GW-1:0] gap;
  logic          tick;
  logic          pending;
  logic          launched;
  logic          go;
  logic          start;
  logic [2:0]    nbytes;
  logic [7:0]    tx;
  logic [2:0]    byte_idx;
  logic [7:0]    rx;
  logic          rx_strobe;
  logic          done;
  logic [2:0]    rx_cnt;
  logic [9:0]    xs;
  logic [9:0]    ys;

  assign tick = init_done && (timer == SW'(SAMPLE_PERIOD - 1));
  assign go   = !launched && (gap == '0);

  gsensor_spi_xfer #(
    .CLK_DIV (CLK_DIV)
  ) u_xfer (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .nbytes    (nbytes),
    .tx        (tx),
    .byte_idx  (byte_idx),
    .rx        (rx),
    .rx_strobe (rx_strobe),
    .done      (done),
    .spi_cs_n  (spi_cs_n),
    .spi_sclk  (spi_sclk),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_PWRUP;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      ST_PWRUP:  if (pw_cnt == PW'(PWRUP_WAIT - 1)) nstate = ST_WR_FMT;
      ST_WR_FMT: if (done) nstate = ST_WR_PWR;
      ST_WR_PWR: if (done) nstate = ST_IDLE;
      ST_IDLE:   if (pending || tick) nstate = ST_READ;
      ST_READ:   if (done) nstate = ST_UPDATE;
      ST_UPDATE: nstate = ST_IDLE;
      default:   nstate = ST_PWRUP;
    endcase
  end

  always_comb begin
    start  = 1'b0;
    nbytes = 3'd2;
    tx     = 8'h00;
    unique case (state)
      ST_WR_FMT: begin
        start = go;
        tx = (byte_idx == 3'd0) ? REG_DATA_FORMAT : CFG_DATA_FORMAT;
      end
      ST_WR_PWR: begin
        start = go;
        tx = (byte_idx == 3'd0) ? REG_POWER_CTL : CFG_POWER_CTL;
      end
      ST_READ: begin
        start  = go;
        nbytes = 3'd5;
        tx = (byte_idx == 3'd0) ? READ_CMD : 8'h00;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pw_cnt    <= '0;
      timer     <= '0;
      gap       <= '0;
      launched  <= 1'b0;
      pending   <= 1'b0;
      rx_cnt    <= '0;
      xs        <= '0;
      ys        <= '0;
      x_acc     <= '0;
      y_acc     <= '0;
      acc_valid <= 1'b0;
      init_done <= 1'b0;
    end else begin
      acc_valid <= 1'b0;
      pw_cnt <= (state == ST_PWRUP) ? pw_cnt + PW'(1) : '0;
      if (!init_done || tick) timer <= '0;
      else                    timer <= timer + SW'(1);
      // cs_n gap counts from the cycle after cs_n rises
      if (done)            gap <= GW'(GAP_LD);
      else if (gap != '0)  gap <= gap - GW'(1);
      if (start)     launched <= 1'b1;
      else if (done) launched <= 1'b0;
      // one-deep request latch; extra ticks are dropped
      if (state == ST_IDLE && nstate == ST_READ) pending <= 1'b0;
      else if (tick)                             pending <= 1'b1;
      if (start)          rx_cnt <= '0;
      else if (rx_strobe) rx_cnt <= rx_cnt + 3'd1;
      if (rx_strobe && state == ST_READ) begin
        unique case (rx_cnt)
          3'd1:    xs[7:0] <= rx;
          3'd2:    xs[9:8] <= rx[1:0];
          3'd3:    ys[7:0] <= rx;
          3'd4:    ys[9:8] <= rx[1:0];
          default: ;
        endcase
      end
      if (state == ST_UPDATE) begin
        x_acc     <= xs;
        y_acc     <= ys;
        acc_valid <= 1'b1;
      end
      if (state == ST_WR_PWR && done) init_done <= 1'b1;
    end
  end

endmodule
